// File: rtl/maq_mh.sv
// Minutes/hours BCD counter with manual time-set mode.
// Advances HH:MM on each incoming minute pulse and flags the 23:59 -> 00:00 day rollover.
module maq_mh #(
    parameter int HORA_INI = 0,
    parameter int MIN_INI  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       incrementa_minuto,
    input  logic       modo_ajuste,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic [3:0] bcd_m_lsd,
    output logic [2:0] bcd_m_msd,
    output logic [3:0] bcd_h_lsd,
    output logic [1:0] bcd_h_msd,
    output logic       incrementa_dia,
    output logic [1:0] campo_sel
);

    typedef enum logic [1:0] {
        NORMAL      = 2'b00,
        AJUSTE_MIN  = 2'b01,
        AJUSTE_HORA = 2'b10,
        INVALIDO    = 2'b11
    } estado_t;

    localparam logic [3:0] M_LSD_INI = 4'(MIN_INI % 10);
    localparam logic [2:0] M_MSD_INI = 3'(MIN_INI / 10);
    localparam logic [3:0] H_LSD_INI = 4'(HORA_INI % 10);
    localparam logic [1:0] H_MSD_INI = 2'(HORA_INI / 10);

    estado_t    state_reg, state_next;
    logic [3:0] m_lsd_reg, m_lsd_next;
    logic [2:0] m_msd_reg, m_msd_next;
    logic [3:0] h_lsd_reg, h_lsd_next;
    logic [1:0] h_msd_reg, h_msd_next;
    logic       dia_reg, dia_next;

    // Wrapped +1 of each field, shared by counting and by set mode
    logic       m_lsd_wrap, min_wrap, h_lsd_wrap, hora_wrap;
    logic [3:0] m_lsd_inc;
    logic [2:0] m_msd_inc;
    logic [3:0] h_lsd_inc;
    logic [1:0] h_msd_inc;

    always_comb begin
        m_lsd_wrap = (m_lsd_reg == 4'd9);
        min_wrap   = m_lsd_wrap && (m_msd_reg == 3'd5);
        h_lsd_wrap = (h_lsd_reg == 4'd9);
        hora_wrap  = (h_msd_reg == 2'd2) && (h_lsd_reg == 4'd3);

        m_lsd_inc = m_lsd_wrap ? 4'd0 : m_lsd_reg + 4'd1;
        if (min_wrap)
            m_msd_inc = 3'd0;
        else if (m_lsd_wrap)
            m_msd_inc = m_msd_reg + 3'd1;
        else
            m_msd_inc = m_msd_reg;

        h_lsd_inc = (hora_wrap || h_lsd_wrap) ? 4'd0 : h_lsd_reg + 4'd1;
        if (hora_wrap)
            h_msd_inc = 2'd0;
        else if (h_lsd_wrap)
            h_msd_inc = h_msd_reg + 2'd1;
        else
            h_msd_inc = h_msd_reg;
    end

    always_comb begin
        state_next = state_reg;
        m_lsd_next = m_lsd_reg;
        m_msd_next = m_msd_reg;
        h_lsd_next = h_lsd_reg;
        h_msd_next = h_msd_reg;
        dia_next   = 1'b0;

        case (state_reg)
            NORMAL: begin
                // A minute pulse arriving with the mode request is still counted
                if (incrementa_minuto) begin
                    m_lsd_next = m_lsd_inc;
                    m_msd_next = m_msd_inc;
                    if (min_wrap) begin
                        h_lsd_next = h_lsd_inc;
                        h_msd_next = h_msd_inc;
                        dia_next   = hora_wrap;
                    end
                end
                if (modo_ajuste)
                    state_next = AJUSTE_MIN;
            end
            AJUSTE_MIN: begin
                if (!modo_ajuste) begin
                    state_next = NORMAL;
                end else begin
                    if (btn_inc) begin
                        m_lsd_next = m_lsd_inc;
                        m_msd_next = m_msd_inc;
                    end
                    if (btn_sel)
                        state_next = AJUSTE_HORA;
                end
            end
            AJUSTE_HORA: begin
                if (!modo_ajuste) begin
                    state_next = NORMAL;
                end else begin
                    if (btn_inc) begin
                        h_lsd_next = h_lsd_inc;
                        h_msd_next = h_msd_inc;
                    end
                    if (btn_sel)
                        state_next = AJUSTE_MIN;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= NORMAL;
            m_lsd_reg <= M_LSD_INI;
            m_msd_reg <= M_MSD_INI;
            h_lsd_reg <= H_LSD_INI;
            h_msd_reg <= H_MSD_INI;
            dia_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            m_lsd_reg <= m_lsd_next;
            m_msd_reg <= m_msd_next;
            h_lsd_reg <= h_lsd_next;
            h_msd_reg <= h_msd_next;
            dia_reg   <= dia_next;
        end
    end

    assign bcd_m_lsd      = m_lsd_reg;
    assign bcd_m_msd      = m_msd_reg;
    assign bcd_h_lsd      = h_lsd_reg;
    assign bcd_h_msd      = h_msd_reg;
    assign incrementa_dia = dia_reg;
    assign campo_sel      = state_reg;

endmodule

// File: tb/tb_maq_mh.sv
// Bench for maq_mh: two instances (00:00 and 23:58 reset values) share stimulus and are
// checked every cycle against a minutes-of-day model, plus literal spot checks.
module tb_maq_mh;

    logic clk = 1'b0;
    logic rst, incrementa_minuto, modo_ajuste, btn_sel, btn_inc;
    logic [3:0] m_lsd [2];
    logic [2:0] m_msd [2];
    logic [3:0] h_lsd [2];
    logic [1:0] h_msd [2];
    logic       dia   [2];
    logic [1:0] cs    [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    maq_mh #(.HORA_INI(0), .MIN_INI(0)) dut0 (
        .clk(clk), .rst(rst), .incrementa_minuto(incrementa_minuto),
        .modo_ajuste(modo_ajuste), .btn_sel(btn_sel), .btn_inc(btn_inc),
        .bcd_m_lsd(m_lsd[0]), .bcd_m_msd(m_msd[0]), .bcd_h_lsd(h_lsd[0]),
        .bcd_h_msd(h_msd[0]), .incrementa_dia(dia[0]), .campo_sel(cs[0])
    );

    maq_mh #(.HORA_INI(23), .MIN_INI(58)) dut1 (
        .clk(clk), .rst(rst), .incrementa_minuto(incrementa_minuto),
        .modo_ajuste(modo_ajuste), .btn_sel(btn_sel), .btn_inc(btn_inc),
        .bcd_m_lsd(m_lsd[1]), .bcd_m_msd(m_msd[1]), .bcd_h_lsd(h_lsd[1]),
        .bcd_h_msd(h_msd[1]), .incrementa_dia(dia[1]), .campo_sel(cs[1])
    );

    // Model: hour/minute as integers, mode as 0 normal / 1 minute / 2 hour
    int ini_h [2] = '{0, 23};
    int ini_m [2] = '{0, 58};
    int mh [2];
    int mm [2];
    int ms [2];
    int md [2];
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int t;
            if (!rst) begin
                mh[i] <= ini_h[i];
                mm[i] <= ini_m[i];
                ms[i] <= 0;
                md[i] <= 0;
            end else begin
                md[i] <= 0;
                if (ms[i] == 0) begin
                    if (incrementa_minuto) begin
                        t = mh[i] * 60 + mm[i] + 1;
                        if (t == 1440) begin
                            t = 0;
                            md[i] <= 1;
                        end
                        mh[i] <= t / 60;
                        mm[i] <= t % 60;
                    end
                    if (modo_ajuste) ms[i] <= 1;
                end else if (!modo_ajuste) begin
                    ms[i] <= 0;
                end else begin
                    if (btn_inc && ms[i] == 1) mm[i] <= (mm[i] + 1) % 60;
                    if (btn_inc && ms[i] == 2) mh[i] <= (mh[i] + 1) % 24;
                    if (btn_sel) ms[i] <= 3 - ms[i];
                end
            end
        end
        if (!rst) mvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (h_msd[i] != 2'(mh[i] / 10) || h_lsd[i] != 4'(mh[i] % 10) ||
                    m_msd[i] != 3'(mm[i] / 10) || m_lsd[i] != 4'(mm[i] % 10) ||
                    cs[i] != 2'(ms[i]) || dia[i] != 1'(md[i])) begin
                    failures++;
                    $display("FAIL cmp dut%0d t=%0t: got %0d%0d:%0d%0d cs=%0d dia=%0d, want %02d:%02d cs=%0d dia=%0d",
                             i, $time, h_msd[i], h_lsd[i], m_msd[i], m_lsd[i], cs[i], dia[i],
                             mh[i], mm[i], ms[i], md[i]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_min(input int n);
        for (int k = 0; k < n; k++) begin
            incrementa_minuto = 1'b1;
            cyc();
            incrementa_minuto = 1'b0;
        end
    endtask

    task automatic chk(input string name, input int i, input int h, input int m,
                       input int c, input int d);
        int gh, gm;
        gh = h_msd[i] * 10 + h_lsd[i];
        gm = m_msd[i] * 10 + m_lsd[i];
        checks++;
        if (gh != h || gm != m || int'(cs[i]) != c || int'(dia[i]) != d) begin
            failures++;
            $display("FAIL %s dut%0d: got %02d:%02d cs=%0d dia=%0d, want %02d:%02d cs=%0d dia=%0d",
                     name, i, gh, gm, cs[i], dia[i], h, m, c, d);
        end else begin
            $display("check %s dut%0d: %02d:%02d cs=%0d dia=%0d", name, i, gh, gm, c, d);
        end
    endtask

    initial begin
        rst = 1'b0; incrementa_minuto = 1'b0; modo_ajuste = 1'b0;
        btn_sel = 1'b0; btn_inc = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        chk("reset", 0, 0, 0, 0, 0);
        chk("reset_ini", 1, 23, 58, 0, 0);

        // Day rollover on the 23:58 instance
        pulse_min(1);
        chk("to_2359", 1, 23, 59, 0, 0);
        pulse_min(1);
        chk("rollover", 1, 0, 0, 0, 1);
        cyc();
        chk("dia_one_cycle", 1, 0, 0, 0, 0);

        // Minute and hour carries
        rst = 1'b0; cyc(); rst = 1'b1;
        pulse_min(9);
        chk("min_0009", 0, 0, 9, 0, 0);
        pulse_min(1);
        chk("min_carry", 0, 0, 10, 0, 0);
        pulse_min(49);
        chk("min_0059", 0, 0, 59, 0, 0);
        pulse_min(1);
        chk("hour_carry", 0, 1, 0, 0, 0);
        pulse_min(539);
        chk("min_0959", 0, 9, 59, 0, 0);
        pulse_min(1);
        chk("hour_tens", 0, 10, 0, 0, 0);

        // Set 12:59 through set mode, then exercise adjust rules
        rst = 1'b0; cyc(); rst = 1'b1;
        modo_ajuste = 1'b1; cyc();
        btn_inc = 1'b1; repeat (59) cyc(); btn_inc = 1'b0;
        btn_sel = 1'b1; cyc(); btn_sel = 1'b0;
        btn_inc = 1'b1; repeat (12) cyc(); btn_inc = 1'b0;
        modo_ajuste = 1'b0; cyc();
        chk("set_1259", 0, 12, 59, 0, 0);
        chk("set_1157", 1, 11, 57, 0, 0);

        modo_ajuste = 1'b1; cyc();
        chk("enter_adj", 0, 12, 59, 1, 0);
        pulse_min(1);
        chk("frozen", 0, 12, 59, 1, 0);
        btn_inc = 1'b1; cyc(); btn_inc = 1'b0;
        chk("min_nocarry", 0, 12, 0, 1, 0);
        btn_sel = 1'b1; cyc(); btn_sel = 1'b0;
        chk("sel_hour", 0, 12, 0, 2, 0);
        btn_inc = 1'b1; repeat (12) cyc(); btn_inc = 1'b0;
        chk("hour_wrap", 0, 0, 0, 2, 0);
        btn_inc = 1'b1; btn_sel = 1'b1; cyc(); btn_inc = 1'b0; btn_sel = 1'b0;
        chk("inc_and_sel", 0, 1, 0, 1, 0);
        modo_ajuste = 1'b0; btn_inc = 1'b1; cyc(); btn_inc = 1'b0;
        chk("exit_ignore", 0, 1, 0, 0, 0);
        modo_ajuste = 1'b1; pulse_min(1);
        chk("count_then_adj", 0, 1, 1, 1, 0);

        // Reset from hour-adjust
        btn_sel = 1'b1; cyc(); btn_sel = 1'b0;
        chk("pre_reset_hour", 0, 1, 1, 2, 0);
        rst = 1'b0; modo_ajuste = 1'b0; cyc(); rst = 1'b1;
        chk("reset_mid_adj", 0, 0, 0, 0, 0);
        pulse_min(3);
        chk("after_reset", 0, 0, 3, 0, 0);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maq_mh.md
Name: maq_mh

Overview:
Minutes/hours BCD counter stage sitting directly downstream of the seconds counter. Consumes its one-cycle incrementa_minuto flag and advances a 24-hour HH:MM time in BCD digits for the display stage. Provides a manual time-set mode driven by pre-debounced button pulses. Emits a one-cycle day-rollover flag for a future date stage.

Parameters:
HORA_INI, 0, hour loaded on reset; legal range 0..23.
MIN_INI, 0, minute loaded on reset; legal range 0..59.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
incrementa_minuto  input  1  one-cycle pulse from the seconds stage; advance one minute
modo_ajuste  input  1  level; high = time-set mode requested
btn_sel  input  1  one-cycle pulse, debounced/synchronised upstream; toggles the selected field
btn_inc  input  1  one-cycle pulse, debounced/synchronised upstream; increments the selected field
bcd_m_lsd  output  4  minute units, 0..9
bcd_m_msd  output  3  minute tens, 0..5
bcd_h_lsd  output  4  hour units, 0..9 (0..3 when hour tens = 2)
bcd_h_msd  output  2  hour tens, 0..2
incrementa_dia  output  1  one-cycle flag on 23:59 -> 00:00 rollover in NORMAL
campo_sel  output  2  00 NORMAL, 01 minute selected, 10 hour selected (equals state)

Behaviour:
- Reset: rst sampled low at a rising edge -> digits = BCD of HORA_INI:MIN_INI, incrementa_dia = 0, state NORMAL, campo_sel = 00. Reset has priority over every other input, including mid-adjust.
- All outputs registered; every update is visible the cycle after the edge that samples the input (1-cycle latency).
- incrementa_dia defaults to 0 every cycle; it is high only in the cycle following a rollover edge.
- States: NORMAL (00), AJUSTE_MIN (01), AJUSTE_HORA (10). Encoding 11 unreachable; if entered, go to NORMAL next edge with digits unchanged.
- NORMAL:
  - modo_ajuste = 1 -> AJUSTE_MIN next edge. incrementa_minuto in the same cycle is still applied (count then enter set mode).
  - incrementa_minuto = 1 -> minute +1 in BCD: m_lsd 9->0 with m_msd +1; at 59 -> 00 with hour carry.
  - Hour +1 in BCD: h_lsd 9->0 with h_msd +1; 23 -> 00.
  - 23:59 + pulse -> 00:00 and incrementa_dia = 1 for one cycle.
- AJUSTE_MIN / AJUSTE_HORA:
  - Time frozen; incrementa_minuto is ignored and lost. No catch-up on exit.
  - btn_inc increments only the selected field, with no carry. Minute 59 -> 00 leaves the hour unchanged. Hour 23 -> 00. incrementa_dia is never asserted.
  - btn_sel toggles AJUSTE_MIN <-> AJUSTE_HORA.
  - btn_inc and btn_sel in the same cycle: the increment applies to the currently selected field; the selection toggles on the same edge.
  - modo_ajuste = 0 -> NORMAL next edge; btn_inc and btn_sel in that cycle are ignored.
- Button inputs held high increment or toggle once per cycle; no edge detection in this block.
- Digit outputs never leave their legal ranges. The hour is always 00..23 and the minute always 00..59.

Test Plan:
- Reset check: HORA_INI = 0, MIN_INI = 0; hold rst low 2 cycles, release -> 00:00, incrementa_dia = 0, campo_sel = 00.
- Minute carry: set 00:09, one incrementa_minuto pulse -> 00:10. From 00:59, one pulse -> 01:00, incrementa_dia stays 0. From 09:59, one pulse -> 10:00 (hour units carry into hour tens).
- Day rollover: HORA_INI = 23, MIN_INI = 58; pulse twice -> 23:59, then 00:00 with incrementa_dia high exactly one cycle.
- Set mode, minute field: at 12:59 raise modo_ajuste -> campo_sel = 01. Apply incrementa_minuto -> still 12:59. btn_inc -> 12:00 (no hour change).
- Set mode, hour field: btn_sel -> campo_sel = 10; btn_inc x12 from 12 -> 00. Assert btn_inc and btn_sel together -> hour 01, campo_sel = 01. Drop modo_ajuste together with btn_inc -> NORMAL, 01:00 unchanged.
- Reset mid-adjust: in AJUSTE_HORA, pulse rst low one cycle -> reset time, campo_sel = 00. Subsequent incrementa_minuto pulses count normally.
